// File: rtl/mult_err_sweeper.sv
// -----------------------------------------------------------------------------
// mult_err_sweeper
//
// Exhaustive error-characterisation engine for an approximate NxN multiplier.
// Walks every (a,b) operand pair through an external combinational multiplier,
// one pair per cycle. It compares each returned product with the exact product
// and accumulates the error count, the sum of error distances and the maximum
// error distance. The accuracy figures are produced in hardware.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      pulse: clear results and begin a sweep (IDLE/DONE only)
//   op_a       out  N      operand a to the multiplier under test (registered)
//   op_b       out  N      operand b to the multiplier under test (registered)
//   approx_y   in   2N     product from the multiplier under test
//   busy       out  1      high from the accepted start until done rises
//   done       out  1      sticky result-valid flag, cleared by the next start
//   err_count  out  2N+1   number of pairs with approx_y != op_a*op_b
//   sum_ed     out  ACC_W  sum of |op_a*op_b - approx_y| (saturating)
//   max_ed     out  2N     largest single |op_a*op_b - approx_y|
// -----------------------------------------------------------------------------
module mult_err_sweeper #(
  parameter int N     = 8,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [N-1:0]       op_a,
  output logic [N-1:0]       op_b,
  input  logic [2*N-1:0]     approx_y,
  output logic               busy,
  output logic               done,
  output logic [2*N:0]       err_count,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [2*N-1:0]     max_ed
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

  localparam logic [N-1:0] OP_MAX = {N{1'b1}};
  localparam logic [N-1:0] OP_ONE = {{(N-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [N-1:0]       op_a_q, op_a_d;
  logic [N-1:0]       op_b_q, op_b_d;
  logic               drain_q, drain_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               s1_valid_q, s1_valid_d;
  logic [2*N-1:0]     s1_exact_q, s1_exact_d;
  logic [2*N-1:0]     s1_approx_q, s1_approx_d;
  logic [2*N:0]       err_q, err_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [2*N-1:0]     max_q, max_d;

  // Stage-2 datapath signals.
  logic [2*N-1:0]     a_ext, b_ext;
  logic [2*N-1:0]     ed;
  logic [ACC_W:0]     sum_ext;

  assign a_ext = {{N{1'b0}}, op_a_q};
  assign b_ext = {{N{1'b0}}, op_b_q};

  // Compare first, then subtract. The error distance is always the smaller
  // value taken from the larger one, so no signed arithmetic is needed.
  assign ed = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                          : (s1_approx_q - s1_exact_q);

  // One spare carry bit detects overflow. With ACC_W >= 4N it never fires,
  // but it keeps the accumulator from wrapping if the design is reused
  // with a narrower ACC_W.
  assign sum_ext = {1'b0, sum_q} + {{(ACC_W + 1 - 2*N){1'b0}}, ed};

  always_comb begin
    // NOTE: every _d gets its hold value first. A branch that does not assign
    // a signal then keeps the flop's value, instead of inferring a latch.
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    done_d      = done_q;
    s1_valid_d  = 1'b0;
    s1_exact_d  = s1_exact_q;
    s1_approx_d = s1_approx_q;
    err_d       = err_q;
    sum_d       = sum_q;
    max_d       = max_q;

    // Stage 2: fold the pair captured last cycle into the results.
    if (s1_valid_q) begin
      err_d = err_q + {{(2*N){1'b0}}, (ed != '0)};
      sum_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      max_d = (ed > max_q) ? ed : max_q;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SWEEP;
          op_a_d  = '0;
          op_b_d  = '0;
          drain_d = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          sum_d   = '0;
          max_d   = '0;
        end
      end

      SWEEP: begin
        // Stage 1: capture the pair currently presented to the multiplier.
        s1_valid_d  = 1'b1;
        s1_exact_d  = a_ext * b_ext;
        s1_approx_d = approx_y;
        if (op_b_q == OP_MAX) begin
          if (op_a_q == OP_MAX) begin
            // The last pair has been captured. The operands hold their value.
            state_d = DRAIN;
          end else begin
            op_b_d = '0;
            op_a_d = op_a_q + OP_ONE;
          end
        end else begin
          op_b_d = op_b_q + OP_ONE;
        end
      end

      DRAIN: begin
        // The first cycle flushes stage 2. The second cycle publishes the results.
        if (drain_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the value its _d had before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      err_q       <= '0;
      sum_q       <= '0;
      max_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_exact_q  <= s1_exact_d;
      s1_approx_q <= s1_approx_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign sum_ed    = sum_q;
  assign max_ed    = max_q;

endmodule

// File: tb/tb_mult_err_sweeper.sv
// -----------------------------------------------------------------------------
// tb_mult_err_sweeper
//
// Directed bench with two instances:
//   dut2 : N=2, ACC_W=8. Fast sweeps with several multiplier models, the
//          operand ordering, ignored starts, restart from DONE, mid-sweep reset.
//   dut8 : N=8, ACC_W=40. One aborted run followed by a full all-zero sweep.
// The expected figures below are hand-computed from the 2-bit product table
//   a\b  0 1 2 3
//   0    0 0 0 0
//   1    0 1 2 3
//   2    0 2 4 6
//   3    0 3 6 9      (sum 36; 4 odd products; 9 non-zero products)
// -----------------------------------------------------------------------------
module tb_mult_err_sweeper;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- N=2 instance ----------------
  logic        rst2_n, start2;
  logic [1:0]  op_a2, op_b2;
  logic [3:0]  approx2, prod2;
  logic        busy2, done2;
  logic [4:0]  err2;
  logic [7:0]  sum2;
  logic [3:0]  max2;
  int          mode2 = 0;

  mult_err_sweeper #(.N(2), .ACC_W(8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .op_a(op_a2), .op_b(op_b2), .approx_y(approx2),
    .busy(busy2), .done(done2),
    .err_count(err2), .sum_ed(sum2), .max_ed(max2)
  );

  // Multiplier models. 0 exact, 1 lsb cleared, 2 zero, 3 lsb forced, 4 all-ones.
  always_comb begin
    prod2 = {2'b00, op_a2} * {2'b00, op_b2};
    case (mode2)
      0:       approx2 = prod2;
      1:       approx2 = prod2 & 4'b1110;
      2:       approx2 = 4'h0;
      3:       approx2 = prod2 | 4'b0001;
      default: approx2 = 4'hF;
    endcase
  end

  // ---------------- N=8 instance ----------------
  logic        rst8_n, start8;
  logic [7:0]  op_a8, op_b8;
  logic [15:0] approx8;
  logic        busy8, done8;
  logic [16:0] err8;
  logic [39:0] sum8;
  logic [15:0] max8;

  assign approx8 = 16'h0000;

  mult_err_sweeper #(.N(8), .ACC_W(40)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8),
    .op_a(op_a8), .op_b(op_b8), .approx_y(approx8),
    .busy(busy8), .done(done8),
    .err_count(err8), .sum_ed(sum8), .max_ed(max8)
  );

  // Full N=2 sweep. ign_at>0 pulses start for one cycle after that many edges
  // (it must be ignored). chk_seq verifies the operand ordering.
  task automatic sweep2(input int mode, input int ign_at, input bit chk_seq,
                        input int e_err, input int e_sum, input int e_max,
                        input string name);
    int edges;
    int k;
    mode2  = mode;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1 || done2 !== 1'b0 || op_a2 !== 2'd0 || op_b2 !== 2'd0 ||
        err2 !== 5'd0 || sum2 !== 8'd0 || max2 !== 4'd0) begin
      failures++;
      $display("FAIL %s_accept: busy=%b done=%b a=%0d b=%0d err=%0d sum=%0d max=%0d want busy=1 done=0 others 0",
               name, busy2, done2, op_a2, op_b2, err2, sum2, max2);
    end
    edges = 0;
    while (done2 !== 1'b1 && edges < 64) begin
      start2 = (ign_at > 0 && edges == ign_at);
      @(posedge clk); #1;
      start2 = 1'b0;
      edges++;
      if (chk_seq && edges <= 16) begin
        k = (edges > 15) ? 15 : edges;
        checks++;
        if (op_a2 !== 2'(k >> 2) || op_b2 !== 2'(k & 3)) begin
          failures++;
          $display("FAIL %s_seq edge %0d: got (%0d,%0d) want (%0d,%0d)",
                   name, edges, op_a2, op_b2, k >> 2, k & 3);
        end
      end
    end
    checks++;
    if (edges != 18 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL %s_latency: done after %0d edges busy=%b, want 18 busy=0", name, edges, busy2);
    end
    checks++;
    if (err2 !== 5'(e_err)) begin
      failures++;
      $display("FAIL %s_err_count: got %0d want %0d", name, err2, e_err);
    end
    checks++;
    if (sum2 !== 8'(e_sum)) begin
      failures++;
      $display("FAIL %s_sum_ed: got %0d want %0d", name, sum2, e_sum);
    end
    checks++;
    if (max2 !== 4'(e_max)) begin
      failures++;
      $display("FAIL %s_max_ed: got %0d want %0d", name, max2, e_max);
    end
  endtask

  task automatic test_reset();
    rst2_n = 1'b0; rst8_n = 1'b0; start2 = 1'b0; start8 = 1'b0;
    #2;
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || op_a2 !== 2'd0 || op_b2 !== 2'd0 ||
        err2 !== 5'd0 || sum2 !== 8'd0 || max2 !== 4'd0) begin
      failures++;
      $display("FAIL reset_n2: busy=%b done=%b a=%0d b=%0d err=%0d sum=%0d max=%0d want all 0",
               busy2, done2, op_a2, op_b2, err2, sum2, max2);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || op_a8 !== 8'd0 || op_b8 !== 8'd0 ||
        err8 !== 17'd0 || sum8 !== 40'd0 || max8 !== 16'd0) begin
      failures++;
      $display("FAIL reset_n8: busy=%b done=%b a=%0d b=%0d err=%0d sum=%0d max=%0d want all 0",
               busy8, done8, op_a8, op_b8, err8, sum8, max8);
    end
    @(negedge clk);
    rst2_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: busy=%b done=%b want 0 0", busy2, done2);
    end
  endtask

  task automatic test_models();
    sweep2(2, 0, 1'b1,  9,  36,  9, "zero_seq");
    sweep2(0, 0, 1'b0,  0,   0,  0, "exact");
    sweep2(1, 0, 1'b0,  4,   4,  1, "lsb_clear");
    sweep2(3, 0, 1'b0, 12,  12,  1, "lsb_set");
    sweep2(4, 0, 1'b0, 16, 204, 15, "all_ones");
  endtask

  task automatic test_done_sticky();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || err2 !== 5'd16 || sum2 !== 8'd204 || max2 !== 4'd15) begin
      failures++;
      $display("FAIL done_sticky: done=%b busy=%b err=%0d sum=%0d max=%0d want 1 0 16 204 15",
               done2, busy2, err2, sum2, max2);
    end
  endtask

  task automatic test_ignored_start();
    sweep2(2, 5,  1'b0, 9, 36, 9, "ign_sweep");
    sweep2(2, 16, 1'b0, 9, 36, 9, "ign_drain");
  endtask

  task automatic test_back_to_back();
    // Restart straight from DONE. The accept checks prove that done fell and
    // the previous non-zero results were cleared.
    sweep2(3, 0, 1'b0, 12, 12, 1, "b2b_first");
    sweep2(0, 0, 1'b0,  0,  0, 0, "b2b_second");
  endtask

  task automatic test_reset_mid_n2();
    mode2  = 4;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst2_n = 1'b0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || op_a2 !== 2'd0 || op_b2 !== 2'd0 ||
        err2 !== 5'd0 || sum2 !== 8'd0 || max2 !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_n2: busy=%b done=%b a=%0d b=%0d err=%0d sum=%0d max=%0d want all 0",
               busy2, done2, op_a2, op_b2, err2, sum2, max2);
    end
    @(negedge clk);
    rst2_n = 1'b1;
    sweep2(2, 0, 1'b0, 9, 36, 9, "after_reset_n2");
  endtask

  task automatic test_n8_reset_then_full();
    int edges;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5000) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0 || err8 === 17'd0) begin
      failures++;
      $display("FAIL n8_partial: busy=%b done=%b err=%0d want busy=1 done=0 err>0", busy8, done8, err8);
    end
    rst8_n = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || op_a8 !== 8'd0 || op_b8 !== 8'd0 ||
        err8 !== 17'd0 || sum8 !== 40'd0 || max8 !== 16'd0) begin
      failures++;
      $display("FAIL n8_reset_mid: busy=%b done=%b a=%0d b=%0d err=%0d sum=%0d max=%0d want all 0",
               busy8, done8, op_a8, op_b8, err8, sum8, max8);
    end
    @(negedge clk);
    rst8_n = 1'b1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || op_a8 !== 8'd0 || op_b8 !== 8'd0 || err8 !== 17'd0) begin
      failures++;
      $display("FAIL n8_accept: busy=%b a=%0d b=%0d err=%0d want 1 0 0 0", busy8, op_a8, op_b8, err8);
    end
    edges = 0;
    while (done8 !== 1'b1 && edges < 70000) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges != 65538) begin
      failures++;
      $display("FAIL n8_latency: done after %0d edges want 65538", edges);
    end
    checks++;
    if (err8 !== 17'd65025) begin
      failures++;
      $display("FAIL n8_err_count: got %0d want 65025", err8);
    end
    checks++;
    if (sum8 !== 40'd1065369600) begin
      failures++;
      $display("FAIL n8_sum_ed: got %0d want 1065369600", sum8);
    end
    checks++;
    if (max8 !== 16'd65025) begin
      failures++;
      $display("FAIL n8_max_ed: got %0d want 65025", max8);
    end
  endtask

  initial begin
    test_reset();
    test_models();
    test_done_sticky();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_n2();
    test_n8_reset_then_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
